// File: rtl/ring_router_demux_multi.sv
// ring_router_demux_multi
// Input demultiplexer of a debug-interconnect ring router. Each DII worm
// arriving from the upstream ring is steered by its header destination ID
// to one of NUM_LOCAL local ports (IDs id_base .. id_base+NUM_LOCAL-1) or
// onward to the downstream ring. With REGISTERED=1 a 2-entry skid buffer
// sits in front of the decision point and in_ring_ready comes from a flop.
//
// Flit layout (18 bits): {data[15:0], last, valid}, valid in bit 0.

module ring_router_demux_multi #(
  parameter int NUM_LOCAL  = 2,
  parameter int REGISTERED = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [9:0]                  id_base,
  input  logic [17:0]                 in_ring,
  output logic                        in_ring_ready,
  output logic [NUM_LOCAL-1:0][17:0]  out_local,
  input  logic [NUM_LOCAL-1:0]        out_local_ready,
  output logic [17:0]                 out_ring,
  input  logic                        out_ring_ready
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WORM = 1'b1
  } state_t;

  // Head flit at the decision point, without its valid bit: {data, last}.
  logic [16:0]          head_body;
  logic                 head_present;
  logic                 head_valid;
  logic                 head_last;
  logic [15:0]          head_data;

  // Route decoded from the head flit's destination field.
  logic [10:0]          diff;
  logic                 hdr_ring;
  logic [3:0]           hdr_port;

  // Worm tracking: state plus the route latched on the header handshake.
  state_t               state;
  state_t               state_next;
  logic                 sel_ring;
  logic [3:0]           sel_port;

  // Route actually in force this cycle.
  logic                 route_ring;
  logic [3:0]           route_port;

  logic                 routed_ready;
  logic                 handshake;
  logic [NUM_LOCAL-1:0] local_valid;
  logic                 ring_valid;

  generate
    if (REGISTERED != 0) begin : g_skid
      // Two-entry buffer; entries hold {data, last} only, presence is
      // tracked by the occupancy count.
      logic [16:0] mem [2];
      logic        rd_ptr;
      logic        wr_ptr;
      logic [1:0]  count;
      logic [1:0]  count_next;
      logic        ready_q;
      logic        push;
      logic        pop;

      assign push = in_ring[0] & ready_q;
      assign pop  = handshake;

      // Next occupancy: a simultaneous push and pop leaves it unchanged.
      always_comb begin
        count_next = count;
        case ({push, pop})
          2'b10:   count_next = count + 2'd1;
          2'b01:   count_next = count - 2'd1;
          default: count_next = count;
        endcase
      end

      // Buffer storage, pointers, occupancy and the registered upstream ready.
      always_ff @(posedge clk) begin
        if (rst) begin
          count   <= 2'd0;
          rd_ptr  <= 1'b0;
          wr_ptr  <= 1'b0;
          ready_q <= 1'b0;
          mem[0]  <= 17'd0;
          mem[1]  <= 17'd0;
        end else begin
          count   <= count_next;
          ready_q <= (count_next < 2'd2);
          if (push) begin
            mem[wr_ptr] <= in_ring[17:1];
            wr_ptr      <= ~wr_ptr;
          end else begin
            wr_ptr      <= wr_ptr;
          end
          if (pop) begin
            rd_ptr <= ~rd_ptr;
          end else begin
            rd_ptr <= rd_ptr;
          end
        end
      end

      assign head_body     = mem[rd_ptr];
      assign head_present  = (count != 2'd0);
      assign in_ring_ready = ready_q;
    end else begin : g_pass
      // Pass-through: the input flit is the head, ready is the routed ready.
      assign head_body     = in_ring[17:1];
      assign head_present  = in_ring[0];
      assign in_ring_ready = routed_ready;
    end
  endgenerate

  // Nothing is offered downstream while reset is asserted.
  assign head_valid = head_present & ~rst;
  assign head_data  = head_body[16:1];
  assign head_last  = head_body[0];

  // Destination decode: a borrow makes diff huge, so IDs below id_base and
  // IDs past the last local port both fall through to the ring (no wrap).
  always_comb begin
    diff = {1'b0, head_data[9:0]} - {1'b0, id_base};
    if (diff < 11'(NUM_LOCAL)) begin
      hdr_ring = 1'b0;
      hdr_port = diff[3:0];
    end else begin
      hdr_ring = 1'b1;
      hdr_port = 4'd0;
    end
  end

  // Route in force: decoded from the head in IDLE, latched value inside a worm.
  always_comb begin
    if (state == ST_WORM) begin
      route_ring = sel_ring;
      route_port = sel_port;
    end else begin
      route_ring = hdr_ring;
      route_port = hdr_port;
    end
  end

  // Port enables and the ready of the routed port; one port valid at most.
  always_comb begin
    local_valid  = {NUM_LOCAL{1'b0}};
    ring_valid   = 1'b0;
    routed_ready = 1'b0;
    if (route_ring) begin
      ring_valid   = head_valid;
      routed_ready = out_ring_ready;
    end else begin
      for (int k = 0; k < NUM_LOCAL; k++) begin
        if (route_port == 4'(k)) begin
          local_valid[k] = head_valid;
          routed_ready   = out_local_ready[k];
        end else begin
          local_valid[k] = 1'b0;
        end
      end
    end
  end

  assign handshake = head_valid & routed_ready;

  // Worm state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Worm next state: a multi-flit header opens a worm, a last flit closes it.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (handshake && !head_last) begin
          state_next = ST_WORM;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WORM: begin
        if (handshake && head_last) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WORM;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Route latch: captured on the header handshake so later id_base changes
  // cannot redirect a worm in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ring <= 1'b1;
      sel_port <= 4'd0;
    end else if ((state == ST_IDLE) && handshake && !head_last) begin
      sel_ring <= hdr_ring;
      sel_port <= hdr_port;
    end else begin
      sel_ring <= sel_ring;
      sel_port <= sel_port;
    end
  end

  // Output flits: every port carries the head payload, only valid differs.
  always_comb begin
    for (int k = 0; k < NUM_LOCAL; k++) begin
      out_local[k] = {head_data, head_last, local_valid[k]};
    end
    out_ring = {head_data, head_last, ring_valid};
  end

endmodule

// File: tb/tb_ring_router_demux_multi.sv
// Bench for ring_router_demux_multi: one pass-through and one skid-buffered
// instance (both NUM_LOCAL=4), directed worms, a per-cycle reference model
// and hand-computed literal expectations.

module tb_ring_router_demux_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [9:0]       id_base;
  logic [17:0]      in0, in1;
  logic             rdy0, rdy1;
  logic [3:0][17:0] loc0, loc1;
  logic [3:0]       lrdy0, lrdy1;
  logic [17:0]      ring0, ring1;
  logic             rrdy0, rrdy1;

  ring_router_demux_multi #(.NUM_LOCAL(4), .REGISTERED(0)) u_dut0 (
    .clk(clk), .rst(rst), .id_base(id_base),
    .in_ring(in0), .in_ring_ready(rdy0),
    .out_local(loc0), .out_local_ready(lrdy0),
    .out_ring(ring0), .out_ring_ready(rrdy0)
  );

  ring_router_demux_multi #(.NUM_LOCAL(4), .REGISTERED(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_base(id_base),
    .in_ring(in1), .in_ring_ready(rdy1),
    .out_local(loc1), .out_local_ready(lrdy1),
    .out_ring(ring1), .out_ring_ready(rrdy1)
  );

  // Valid vectors as {ring, local3, local2, local1, local0}.
  logic [4:0] v0, v1;
  assign v0 = {ring0[0], loc0[3][0], loc0[2][0], loc0[1][0], loc0[0][0]};
  assign v1 = {ring1[0], loc1[3][0], loc1[2][0], loc1[1][0], loc1[0][0]};

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Destination to port index (4 = ring), plain integer arithmetic.
  function automatic int route_of(input logic [9:0] dest, input logic [9:0] base);
    int dv, bv, d;
    dv = {22'd0, dest};
    bv = {22'd0, base};
    d  = dv - bv;
    if (d >= 0 && d < 4) return d;
    return 4;
  endfunction

  function automatic logic ready_of(input int p, input logic [3:0] lr, input logic rr);
    if (p == 4) return rr;
    return lr[p];
  endfunction

  function automatic logic [4:0] onehot(input int p);
    logic [4:0] v;
    v = 5'd0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Reference model state.
  bit          check_en = 1'b0;
  bit          m0_worm = 1'b0;
  int          m0_port = 4;
  bit          m1_worm = 1'b0;
  int          m1_port = 4;
  logic [16:0] q1[$];
  bit          rst_at_edge = 1'b1;
  logic [15:0] got_q[$];

  // Per-cycle comparison against the model; also advances the model to
  // the state after the coming rising edge (inputs are stable until then).
  always @(negedge clk) begin : cmp
    int p0, p1;
    logic [4:0] e0, e1;
    logic er0, er1, hs0, pop1, push1;
    if (check_en) begin
      // pass-through instance
      p0  = m0_worm ? m0_port : route_of(in0[11:2], id_base);
      e0  = (in0[0] && !rst) ? onehot(p0) : 5'd0;
      er0 = ready_of(p0, lrdy0, rrdy0);
      chk("m0_valid", 32'(v0), 32'(e0));
      chk("m0_ready", 32'(rdy0), 32'(er0));
      for (int k = 0; k < 4; k++) chk("m0_local_payload", 32'(loc0[k][17:1]), 32'(in0[17:1]));
      chk("m0_ring_payload", 32'(ring0[17:1]), 32'(in0[17:1]));
      hs0 = in0[0] && !rst && er0;
      if (rst) m0_worm = 1'b0;
      else if (hs0) begin
        if (in0[1]) m0_worm = 1'b0;
        else begin m0_worm = 1'b1; m0_port = p0; end
      end
      // buffered instance
      er1 = rst_at_edge ? 1'b0 : (q1.size() < 2);
      chk("m1_ready", 32'(rdy1), 32'(er1));
      if (q1.size() > 0 && !rst) begin
        p1 = m1_worm ? m1_port : route_of(q1[0][10:1], id_base);
        e1 = onehot(p1);
      end else begin
        p1 = 4;
        e1 = 5'd0;
      end
      chk("m1_valid", 32'(v1), 32'(e1));
      if (e1 != 5'd0) begin
        chk("m1_ring_payload", 32'(ring1[17:1]), 32'(q1[0]));
        for (int k = 0; k < 4; k++) chk("m1_local_payload", 32'(loc1[k][17:1]), 32'(q1[0]));
      end
      pop1  = (e1 != 5'd0) && ready_of(p1, lrdy1, rrdy1);
      push1 = !rst && in1[0] && er1;
      if (rst) begin
        q1.delete();
        m1_worm = 1'b0;
      end else begin
        if (pop1) begin
          if (q1[0][0]) m1_worm = 1'b0;
          else begin m1_worm = 1'b1; m1_port = p1; end
          void'(q1.pop_front());
        end
        if (push1) q1.push_back(in1[17:1]);
      end
      rst_at_edge = rst;
    end
  end

  // Collects payloads delivered on the buffered instance's ring output.
  always @(negedge clk) begin
    if (check_en && !rst && ring1[0] && rrdy1) got_q.push_back(ring1[17:2]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pass-through flit with a literal expected valid vector.
  task automatic step0(input logic [15:0] d, input logic l, input logic [4:0] exp, input string name);
    in0 = {d, l, 1'b1};
    @(negedge clk);
    chk(name, 32'(v0), 32'(exp));
    tick();
    in0 = 18'd0;
  endtask

  // Offer one flit to the buffered instance until it is accepted (bounded).
  task automatic send1(input logic [15:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    in1 = {d, l, 1'b1};
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = rdy1;
      tick();
    end
    if (!acc) chk("send1_timeout", 32'(0), 32'(1));
    in1 = 18'd0;
  endtask

  logic [15:0] exp_ring [6] = '{16'h0030, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; id_base = 10'h010;
    in0 = 18'd0; in1 = 18'd0;
    lrdy0 = 4'hF; lrdy1 = 4'hF; rrdy0 = 1'b1; rrdy1 = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid0", 32'(v0), 32'(0));
    chk("reset_valid1", 32'(v1), 32'(0));
    chk("reset_ready1_release_cycle", 32'(rdy1), 32'(0));
    tick();
    @(negedge clk);
    chk("ready1_after_release", 32'(rdy1), 32'(1));
    tick();

    // 3-flit worm to local 2; body payloads would decode elsewhere
    step0(16'h0012, 1'b0, 5'b00100, "worm_hdr_l2");
    step0(16'hABCD, 1'b0, 5'b00100, "worm_body_l2");
    step0(16'h0005, 1'b1, 5'b00100, "worm_last_l2");
    step0(16'h000F, 1'b1, 5'b10000, "idle_after_last_00f_ring");
    step0(16'h0014, 1'b1, 5'b10000, "dest_014_ring");
    step0(16'hFC11, 1'b1, 5'b00010, "upper_bits_ignored_l1");
    id_base = 10'h3FE;
    step0(16'h03FF, 1'b1, 5'b00010, "dest_3ff_l1");
    step0(16'h0000, 1'b1, 5'b10000, "no_wrap_000_ring");
    step0(16'h03FE, 1'b1, 5'b00001, "dest_3fe_l0");
    id_base = 10'h010;
    step0(16'h0011, 1'b1, 5'b00010, "single_011_l1");
    step0(16'h0030, 1'b1, 5'b10000, "single_030_ring_b2b");
    // id_base change inside a worm to local 0
    step0(16'h0010, 1'b0, 5'b00001, "hdr_l0");
    id_base = 10'h000;
    step0(16'h0013, 1'b0, 5'b00001, "body_l0_base_changed");
    step0(16'h0013, 1'b1, 5'b00001, "last_l0_base_changed");
    step0(16'h0002, 1'b1, 5'b00100, "new_base_002_l2");
    id_base = 10'h010;
    // stall on local 0 blocks the header
    lrdy0 = 4'b1110;
    in0 = {16'h0010, 1'b0, 1'b1};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("stall_ready0_low", 32'(rdy0), 32'(0));
      chk("stall_valid_held", 32'(v0), 32'(5'b00001));
      tick();
    end
    lrdy0 = 4'hF;
    step0(16'h0010, 1'b0, 5'b00001, "stall_release_hdr_l0");
    step0(16'h7777, 1'b1, 5'b00001, "body_after_stall_l0");

    // buffered instance: back-to-back worm to local 2
    for (int i = 0; i < 3; i++) begin
      in1 = {(i == 0) ? 16'h0012 : 16'h0100 * i[15:0], (i == 2), 1'b1};
      @(negedge clk);
      chk("r1_tput_ready", 32'(rdy1), 32'(1));
      tick();
    end
    in1 = 18'd0;
    @(negedge clk);
    chk("r1_last_presented_l2", 32'(v1), 32'(5'b00100));
    chk("r1_last_data", 32'(loc1[2][17:2]), 32'(16'h0200));
    tick();
    @(negedge clk);
    chk("r1_drained", 32'(v1), 32'(0));
    tick();

    // buffered instance: 6-flit ring worm with a 4-cycle downstream stall
    rrdy1 = 1'b0;
    in1 = {16'h0030, 1'b0, 1'b1};
    @(negedge clk);
    chk("skid_c0_ready", 32'(rdy1), 32'(1));
    tick();
    in1 = {16'h1111, 1'b0, 1'b1};
    @(negedge clk);
    chk("skid_latency_valid", 32'(v1), 32'(5'b10000));
    chk("skid_latency_data", 32'(ring1[17:2]), 32'(16'h0030));
    chk("skid_c1_ready", 32'(rdy1), 32'(1));
    tick();
    in1 = {16'h2222, 1'b0, 1'b1};
    for (int c = 2; c < 4; c++) begin
      @(negedge clk);
      chk("skid_full_ready_low", 32'(rdy1), 32'(0));
      tick();
    end
    rrdy1 = 1'b1;
    @(negedge clk);
    chk("skid_ready_low_at_first_pop", 32'(rdy1), 32'(0));
    tick();
    @(negedge clk);
    chk("skid_ready_rises", 32'(rdy1), 32'(1));
    tick();
    send1(16'h3333, 1'b0);
    send1(16'h4444, 1'b0);
    send1(16'h5555, 1'b1);
    for (int t = 0; t < 20 && got_q.size() < 6; t++) tick();
    chk("skid_flit_count", 32'(got_q.size()), 32'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) chk("skid_order", 32'(got_q[i]), 32'(exp_ring[i]));
      else chk("skid_missing", 32'(0), 32'(exp_ring[i]));
    end

    // reset in the middle of worms on both instances
    in0 = {16'h0012, 1'b0, 1'b1};
    in1 = {16'h0011, 1'b0, 1'b1};
    @(negedge clk);
    chk("r0_pre_rst_hdr_l2", 32'(v0), 32'(5'b00100));
    tick();
    in0 = {16'h0005, 1'b0, 1'b1};
    in1 = {16'h0005, 1'b0, 1'b1};
    @(negedge clk);
    chk("r1_pre_rst_hdr_l1", 32'(v1), 32'(5'b00010));
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid0", 32'(v0), 32'(0));
    chk("rst_valid1", 32'(v1), 32'(0));
    tick();
    @(negedge clk);
    chk("rst_valid0_held", 32'(v0), 32'(0));
    chk("rst_valid1_held", 32'(v1), 32'(0));
    chk("rst_ready1_low", 32'(rdy1), 32'(0));
    tick();
    rst = 1'b0;
    in0 = {16'h0010, 1'b1, 1'b1};
    in1 = {16'h0010, 1'b1, 1'b1};
    @(negedge clk);
    chk("r0_post_rst_hdr_l0", 32'(v0), 32'(5'b00001));
    tick();
    in0 = 18'd0;
    @(negedge clk);
    chk("r1_ready_after_rst", 32'(rdy1), 32'(1));
    tick();
    in1 = 18'd0;
    @(negedge clk);
    chk("r1_post_rst_hdr_l0", 32'(v1), 32'(5'b00001));
    tick();
    tick();
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
